// File: rtl/pwm_audio_out_pkg.sv
// Shared types and helpers for the PWM audio output stage.
package pwm_audio_out_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      RAMP_UP   = 2'd1,
      RUN       = 2'd2,
      RAMP_DOWN = 2'd3
   } pwm_state_e;

   // Width of the requantisation residue carried between frames.
   function automatic int err_width(input int sample_w, input int pwm_w);
      return sample_w - pwm_w;
   endfunction

endpackage

// File: rtl/pwm_audio_out_requant.sv
// Combinational requantiser: folds the carried residue into the sample and
// splits the sum into a PWM duty and the next residue, saturating on overflow.
module pwm_audio_out_requant #(
   parameter int SAMPLE_W    = 12,
   parameter int PWM_W       = 8,
   parameter int NOISE_SHAPE = 1
) (
   input  logic [SAMPLE_W-1:0]       src,
   input  logic [SAMPLE_W-PWM_W-1:0] err_in,
   output logic [PWM_W-1:0]          duty_q,
   output logic [SAMPLE_W-PWM_W-1:0] err_q
);
   import pwm_audio_out_pkg::*;

   localparam int ERR_W = err_width(SAMPLE_W, PWM_W);

   logic [SAMPLE_W:0] acc;

   always_comb begin
      acc    = {1'b0, src} + {{(PWM_W + 1){1'b0}}, err_in};
      duty_q = acc[SAMPLE_W-1 -: PWM_W];
      err_q  = acc[ERR_W-1:0];
      if (acc[SAMPLE_W]) begin
         duty_q = '1;
         err_q  = '0;
      end
      if (NOISE_SHAPE == 0) begin
         err_q = '0;
      end
   end

endmodule

// File: rtl/pwm_audio_out.sv
// Audio output stage: 1-deep sample buffer, fixed-period PWM frames,
// error-feedback requantisation and pop-free ramps on enable/disable.
module pwm_audio_out #(
   parameter int SAMPLE_W    = 12,
   parameter int PWM_W       = 8,
   parameter int NOISE_SHAPE = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ena,
   input  logic [SAMPLE_W-1:0] sample_in,
   input  logic                sample_valid,
   output logic                sample_ready,
   output logic                pwm_out,
   output logic                frame_start,
   output logic                underrun
);
   import pwm_audio_out_pkg::*;

   localparam int ERR_W = err_width(SAMPLE_W, PWM_W);
   localparam logic [SAMPLE_W-1:0] SAMPLE_MID = {1'b1, {(SAMPLE_W - 1){1'b0}}};
   localparam logic [PWM_W-1:0]    PWM_MID    = {1'b1, {(PWM_W - 1){1'b0}}};

   pwm_state_e          state, state_n;
   logic [PWM_W-1:0]    cnt;
   logic [PWM_W-1:0]    duty, duty_n;
   logic [ERR_W-1:0]    err, err_n;
   logic [SAMPLE_W-1:0] last, last_n;
   logic [SAMPLE_W-1:0] pend;
   logic                pend_valid;
   logic                pend_drop;
   logic                underrun_n;
   logic                boundary;
   logic [SAMPLE_W-1:0] src;
   logic [PWM_W-1:0]    q_duty;
   logic [ERR_W-1:0]    q_err;
   logic [PWM_W-1:0]    up_duty;
   logic [PWM_W-1:0]    down_duty;

   assign boundary     = (cnt == {PWM_W{1'b1}});
   assign frame_start  = (cnt == '0);
   assign sample_ready = (state == RUN) && ena && !pend_valid;
   assign src          = pend_valid ? pend : last;

   // Ramping up heads for mid-scale from either side, so re-enabling
   // during a ramp-down from a loud sample still converges.
   assign up_duty   = (duty < PWM_MID) ? duty + PWM_W'(1) :
                      (duty > PWM_MID) ? duty - PWM_W'(1) : duty;
   assign down_duty = (duty == '0) ? '0 : duty - PWM_W'(1);

   pwm_audio_out_requant #(
      .SAMPLE_W    (SAMPLE_W),
      .PWM_W       (PWM_W),
      .NOISE_SHAPE (NOISE_SHAPE)
   ) u_requant (
      .src    (src),
      .err_in (err),
      .duty_q (q_duty),
      .err_q  (q_err)
   );

   // Frame-boundary decisions: state, duty and residue only move when the
   // counter is about to wrap, so every PWM frame has a constant duty.
   always_comb begin
      state_n    = state;
      duty_n     = duty;
      err_n      = err;
      last_n     = last;
      pend_drop  = 1'b0;
      underrun_n = 1'b0;
      if (boundary) begin
         case (state)
            IDLE: begin
               duty_n = '0;
               err_n  = '0;
               if (ena) begin
                  duty_n  = PWM_W'(1);
                  state_n = RAMP_UP;
               end
            end
            RUN: begin
               pend_drop = 1'b1;
               if (ena) begin
                  duty_n     = q_duty;
                  err_n      = q_err;
                  last_n     = src;
                  underrun_n = !pend_valid;
               end else begin
                  err_n   = '0;
                  duty_n  = down_duty;
                  state_n = (down_duty == '0) ? IDLE : RAMP_DOWN;
               end
            end
            default: begin
               if (ena) begin
                  duty_n = up_duty;
                  if (up_duty == PWM_MID) begin
                     state_n = RUN;
                     err_n   = '0;
                     last_n  = SAMPLE_MID;
                  end else begin
                     state_n = RAMP_UP;
                  end
               end else begin
                  duty_n = down_duty;
                  if (down_duty == '0) begin
                     state_n = IDLE;
                     err_n   = '0;
                  end else begin
                     state_n = RAMP_DOWN;
                  end
               end
            end
         endcase
      end
   end

   // A transfer on the boundary cycle wins over the drop, so the sample
   // is held for the following frame rather than lost.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt        <= '0;
         state      <= IDLE;
         duty       <= '0;
         err        <= '0;
         last       <= SAMPLE_MID;
         pend       <= '0;
         pend_valid <= 1'b0;
         pwm_out    <= 1'b0;
         underrun   <= 1'b0;
      end else begin
         cnt      <= cnt + PWM_W'(1);
         pwm_out  <= (cnt < duty);
         state    <= state_n;
         duty     <= duty_n;
         err      <= (NOISE_SHAPE != 0) ? err_n : '0;
         last     <= last_n;
         underrun <= underrun_n;
         if (sample_valid && sample_ready) begin
            pend       <= sample_in;
            pend_valid <= 1'b1;
         end else if (pend_drop) begin
            pend_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pwm_audio_out.sv
// Self-checking bench for pwm_audio_out: directed scenarios plus randomized
// traffic, compared cycle by cycle against a frame-level arithmetic model.
module tb_pwm_audio_out;

   localparam int SW    = 10;
   localparam int PW    = 6;
   localparam int FRAME = 1 << PW;
   localparam int PMID  = FRAME / 2;
   localparam int SMID  = 1 << (SW - 1);
   localparam int ERRL  = 1 << (SW - PW);
   localparam int SMAX  = (1 << SW) - 1;

   localparam int MODE_OFF  = 0;
   localparam int MODE_UP   = 1;
   localparam int MODE_PLAY = 2;
   localparam int MODE_DOWN = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          ena;
   logic [SW-1:0] sample_in;
   logic          sample_valid;
   logic          sample_ready;
   logic          pwm_out;
   logic          frame_start;
   logic          underrun;

   int n_compared   = 0;
   int n_mismatched = 0;

   int m_cnt   = 0;
   int m_duty  = 0;
   int m_mode  = MODE_OFF;
   int m_err   = 0;
   int m_last  = SMID;
   int m_pend  = 0;
   int m_pendv = 0;
   int m_pwm   = 0;
   int m_under = 0;

   int h;
   int u;
   int total;

   pwm_audio_out #(
      .SAMPLE_W    (SW),
      .PWM_W       (PW),
      .NOISE_SHAPE (1)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .ena          (ena),
      .sample_in    (sample_in),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .pwm_out      (pwm_out),
      .frame_start  (frame_start),
      .underrun     (underrun)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_compared++;
      assert (observed === expected) else begin
         n_mismatched++;
         $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic valid, input logic [SW-1:0] data);
      sample_valid = valid;
      sample_in    = data;
   endtask

   function automatic bit modelReady();
      return (m_mode == MODE_PLAY) && (ena === 1'b1) && (m_pendv == 0);
   endfunction

   task automatic modelUp();
      if (m_duty < PMID) m_duty++;
      else if (m_duty > PMID) m_duty--;
      if (m_duty == PMID) begin
         m_mode = MODE_PLAY;
         m_err  = 0;
         m_last = SMID;
      end else begin
         m_mode = MODE_UP;
      end
   endtask

   task automatic modelDown();
      if (m_duty > 0) m_duty--;
      if (m_duty == 0) begin
         m_mode = MODE_OFF;
         m_err  = 0;
      end else begin
         m_mode = MODE_DOWN;
      end
   endtask

   // One frame decision: integer arithmetic on the sample value, with the
   // residue carried as the remainder of a division by the duty step.
   task automatic modelBoundary();
      int src;
      int acc;
      case (m_mode)
         MODE_OFF: begin
            m_duty = 0;
            m_err  = 0;
            if (ena) begin
               m_duty = 1;
               m_mode = MODE_UP;
            end
         end
         MODE_PLAY: begin
            if (ena) begin
               src = (m_pendv != 0) ? m_pend : m_last;
               acc = src + m_err;
               if (acc > SMAX) begin
                  m_duty = FRAME - 1;
                  m_err  = 0;
               end else begin
                  m_duty = acc / ERRL;
                  m_err  = acc % ERRL;
               end
               if (m_pendv == 0) m_under = 1;
               m_last  = src;
               m_pendv = 0;
            end else begin
               m_pendv = 0;
               m_err   = 0;
               modelDown();
            end
         end
         default: begin
            if (ena) modelUp();
            else modelDown();
         end
      endcase
   endtask

   task automatic modelEdge();
      bit take;
      int nxt_pwm;
      if (rst) begin
         m_cnt   = 0;
         m_mode  = MODE_OFF;
         m_duty  = 0;
         m_err   = 0;
         m_pendv = 0;
         m_pend  = 0;
         m_last  = SMID;
         m_pwm   = 0;
         m_under = 0;
      end else begin
         take    = modelReady() && (sample_valid === 1'b1);
         nxt_pwm = (m_cnt < m_duty) ? 1 : 0;
         m_under = 0;
         if (m_cnt == FRAME - 1) modelBoundary();
         if (take) begin
            m_pend  = int'(sample_in);
            m_pendv = 1;
         end
         m_pwm = nxt_pwm;
         m_cnt = (m_cnt + 1) % FRAME;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      modelEdge();
      @(negedge clk);
      checkOutput("pwm_out", 32'(pwm_out), 32'(m_pwm));
      checkOutput("underrun", 32'(underrun), 32'(m_under));
      checkOutput("frame_start", 32'(frame_start), (m_cnt == 0) ? 32'd1 : 32'd0);
      checkOutput("sample_ready", 32'(sample_ready), 32'(modelReady()));
   endtask

   task automatic alignFrame();
      for (int i = 0; i < FRAME && m_cnt != 0; i++) tick();
      checkOutput("frame_align", 32'(frame_start), 32'd1);
   endtask

   // Runs one whole frame from cnt==0, optionally handing over one sample.
   task automatic frameRun(input bit send, input logic [SW-1:0] s, output int highs, output int unders);
      bit pending;
      pending = send;
      highs   = 0;
      unders  = 0;
      for (int i = 0; i < FRAME; i++) begin
         if (pending && modelReady()) begin
            applyStimulus(1'b1, s);
            pending = 1'b0;
         end else begin
            applyStimulus(1'b0, '0);
         end
         tick();
         highs  += int'(pwm_out);
         unders += int'(underrun);
      end
      applyStimulus(1'b0, '0);
   endtask

   initial begin
      rst = 1'b1;
      ena = 1'b0;
      applyStimulus(1'b0, '0);
      tick();
      tick();
      checkOutput("reset_pwm", 32'(pwm_out), 32'd0);
      checkOutput("reset_ready", 32'(sample_ready), 32'd0);
      checkOutput("reset_underrun", 32'(underrun), 32'd0);
      checkOutput("reset_cnt", 32'(frame_start), 32'd1);

      $display("[TB] ramp up from reset");
      rst = 1'b0;
      ena = 1'b1;
      frameRun(1'b0, '0, h, u);
      checkOutput("frame0_low", 32'(h), 32'd0);
      for (int j = 1; j < PMID; j++) begin
         frameRun(1'b0, '0, h, u);
         checkOutput("ramp_up_duty", 32'(h), 32'(j));
      end
      checkOutput("ready_after_ramp", 32'(sample_ready), 32'd1);

      $display("[TB] single sample then repeat");
      frameRun(1'b1, SW'(SMID + SMID / 2), h, u);
      checkOutput("run_mid_frame", 32'(h), 32'(PMID));
      checkOutput("no_underrun_with_pending", 32'(u), 32'd0);
      frameRun(1'b0, '0, h, u);
      checkOutput("three_quarter_frame", 32'(h), 32'(FRAME * 3 / 4));
      checkOutput("underrun_first", 32'(u), 32'd1);
      frameRun(1'b0, '0, h, u);
      checkOutput("three_quarter_repeat", 32'(h), 32'(FRAME * 3 / 4));
      checkOutput("underrun_repeat", 32'(u), 32'd1);

      $display("[TB] dithered mid-scale");
      total = 0;
      for (int i = 0; i < 16; i++) begin
         frameRun(1'b1, SW'(SMID + ERRL / 2), h, u);
         if (i > 0) total += h;
      end
      frameRun(1'b0, '0, h, u);
      total += h;
      checkOutput("dither_sum", 32'(total), 32'(16 * (SMID + ERRL / 2) / ERRL));

      $display("[TB] saturation");
      frameRun(1'b1, SW'(SMAX), h, u);
      for (int i = 0; i < 3; i++) begin
         frameRun(1'b1, SW'(SMAX), h, u);
         checkOutput("sat_frame", 32'(h), 32'(FRAME - 1));
      end
      frameRun(1'b0, '0, h, u);
      checkOutput("sat_repeat", 32'(h), 32'(FRAME - 1));

      $display("[TB] disable from three-quarter duty");
      frameRun(1'b1, SW'(SMID + SMID / 2), h, u);
      u = 0;
      for (int i = 0; i < 8 && !modelReady(); i++) tick();
      applyStimulus(1'b1, SW'(SMAX));
      tick();
      applyStimulus(1'b0, '0);
      tick();
      ena = 1'b0;
      #1;
      checkOutput("ready_drop", 32'(sample_ready), 32'd0);
      total = 0;
      for (int i = 0; i < FRAME && m_cnt != 0; i++) begin
         tick();
         total += int'(underrun);
      end
      for (int j = 1; j <= FRAME * 3 / 4; j++) begin
         frameRun(1'b0, '0, h, u);
         total += u;
         checkOutput("ramp_down_duty", 32'(h), 32'(FRAME * 3 / 4 - j));
      end
      checkOutput("ramp_down_underrun", 32'(total), 32'd0);

      $display("[TB] reset during ramp up");
      ena = 1'b1;
      for (int i = 0; i < PMID / 2; i++) frameRun(1'b0, '0, h, u);
      for (int i = 0; i < 10; i++) tick();
      rst = 1'b1;
      tick();
      checkOutput("rst_pwm", 32'(pwm_out), 32'd0);
      checkOutput("rst_cnt", 32'(frame_start), 32'd1);
      checkOutput("rst_ready", 32'(sample_ready), 32'd0);
      rst = 1'b0;
      frameRun(1'b0, '0, h, u);
      checkOutput("restart_frame0", 32'(h), 32'd0);
      frameRun(1'b0, '0, h, u);
      checkOutput("restart_frame1", 32'(h), 32'd1);
      for (int i = 0; i < PMID - 2; i++) frameRun(1'b0, '0, h, u);
      checkOutput("ready_after_restart", 32'(sample_ready), 32'd1);

      $display("[TB] randomized traffic");
      for (int c = 0; c < FRAME * 80; c++) begin
         if ($urandom_range(0, 3) == 0)
            applyStimulus($urandom_range(0, 2) == 0, SW'($urandom_range(SMAX - 40, SMAX)));
         else
            applyStimulus($urandom_range(0, 2) == 0, SW'($urandom_range(0, SMAX)));
         if (c > FRAME * 40 && $urandom_range(0, FRAME * 12) == 0) ena = ~ena;
         rst = ($urandom_range(0, FRAME * 60) == 0);
         tick();
      end
      rst = 1'b0;
      applyStimulus(1'b0, '0);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
